// File: rtl/onehot_event_serializer.sv
// rtl/onehot_event_serializer.sv - captures request events and presents them one at a time as a one-hot word, round-robin
module onehot_event_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] out_onehot,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;

    logic          xfer;
    logic [N-1:0]  ack_mask;
    logic [N-1:0]  avail;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] base;
    logic [IW-1:0] j;
    logic [N-1:0]  sel_onehot;
    logic          sel_found;

    assign xfer     = out_valid & out_ready;
    assign ack_mask = xfer ? out_onehot : '0;
    assign avail    = pending & ~ack_mask;

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (out_onehot[i]) begin
                cur_idx = IW'(i);
            end
        end
    end

    // After a transfer the presented bit becomes the new round-robin anchor
    // in the same cycle, so the next search already skips past it.
    assign base = xfer ? cur_idx : last_grant;

    always_comb begin
        sel_onehot = '0;
        sel_found  = 1'b0;
        j          = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(base) + i) % N);
            if (!sel_found && avail[j]) begin
                sel_found     = 1'b1;
                sel_onehot[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            state      <= IDLE;
            last_grant <= IW'(N - 1);
        end else begin
            pending  <= avail | req_in;
            overflow <= |(req_in & avail);
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_onehot <= sel_onehot;
                        out_valid  <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Hold the presented word untouched until it is accepted.
                    if (out_ready) begin
                        last_grant <= cur_idx;
                        if (sel_found) begin
                            out_onehot <= sel_onehot;
                        end else begin
                            out_onehot <= '0;
                            out_valid  <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    out_onehot <= '0;
                    out_valid  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_event_serializer.sv
// tb/tb_onehot_event_serializer.sv - directed bench with a queue-free event model and per-cycle compare
module tb_onehot_event_serializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_in = '0;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_onehot;
    logic         out_valid;
    logic [N-1:0] pending;
    logic         overflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    onehot_event_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Model: a set of pending events, the index currently offered (-1 when
    // nothing is offered) and the index last handed downstream.
    bit [N-1:0] m_pend = '0;
    int         m_cur  = -1;
    int         m_last = N - 1;
    bit         m_ovf  = 1'b0;
    bit [N-1:0] m_p;
    bit         m_x;

    function automatic int pick(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = '0;
            m_cur  = -1;
            m_last = N - 1;
            m_ovf  = 1'b0;
        end else begin
            m_p = m_pend;
            m_x = (m_cur >= 0) && out_ready;
            if (m_x) m_p[m_cur] = 1'b0;
            m_ovf = |(req_in & m_p);
            if (m_cur < 0) begin
                m_cur = pick(m_pend, m_last);
            end else if (m_x) begin
                m_last = m_cur;
                m_cur  = pick(m_p, m_last);
            end
            m_pend = m_p | req_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    bit [N-1:0] m_oh;
    always @(negedge clk) begin
        if (chk_en) begin
            m_oh = '0;
            if (m_cur >= 0) m_oh[m_cur] = 1'b1;
            check("model_pending",  32'(pending),    32'(m_pend));
            check("model_onehot",   32'(out_onehot), 32'(m_oh));
            check("model_valid",    32'(out_valid),  32'(m_cur >= 0));
            check("model_overflow", 32'(overflow),   32'(m_ovf));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        do_reset();
        chk_en = 1'b1;
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_valid",   32'(out_valid), 32'h0);
        check("reset_onehot",  32'(out_onehot), 32'h0);
        check("reset_ovf",     32'(overflow), 32'h0);

        // 1: single event latency
        out_ready = 1'b1; req_in = 8'h04; step();
        check("t1_pending_e0", 32'(pending), 32'h04);
        check("t1_valid_e0",   32'(out_valid), 32'h0);
        req_in = 8'h00; step();
        check("t1_onehot_e1",  32'(out_onehot), 32'h04);
        check("t1_valid_e1",   32'(out_valid), 32'h1);
        step();
        check("t1_valid_e2",   32'(out_valid), 32'h0);
        check("t1_pending_e2", 32'(pending), 32'h00);

        // 2: two events, back to back, wrap order from bit 0
        do_reset();
        out_ready = 1'b1; req_in = 8'h81; step();
        req_in = 8'h00; step();
        check("t2_first",  32'(out_onehot), 32'h01);
        step();
        check("t2_second", 32'(out_onehot), 32'h80);
        check("t2_ovf",    32'(overflow), 32'h0);
        step();
        check("t2_idle",   32'(out_valid), 32'h0);

        // 3: backpressure with last_grant=2
        do_reset();
        out_ready = 1'b1; req_in = 8'h04; step();
        req_in = 8'h00; step();
        step();
        out_ready = 1'b0; req_in = 8'h0F; step();
        req_in = 8'h00; step();
        for (int c = 0; c < 5; c++) begin
            check("t3_hold", 32'(out_onehot), 32'h08);
            step();
        end
        check("t3_hold_pending", 32'(pending), 32'h0F);
        out_ready = 1'b1; step();
        check("t3_seq1", 32'(out_onehot), 32'h01);
        step();
        check("t3_seq2", 32'(out_onehot), 32'h02);
        step();
        check("t3_seq3", 32'(out_onehot), 32'h04);
        step();
        check("t3_idle", 32'(out_valid), 32'h0);

        // 4: overflow on a repeated, unacknowledged event
        do_reset();
        out_ready = 1'b0; req_in = 8'h10; step();
        check("t4_ovf_first", 32'(overflow), 32'h0);
        step();
        check("t4_ovf_pulse", 32'(overflow), 32'h1);
        req_in = 8'h00; step();
        check("t4_ovf_gone",  32'(overflow), 32'h0);
        check("t4_pending",   32'(pending), 32'h10);
        check("t4_onehot",    32'(out_onehot), 32'h10);
        out_ready = 1'b1; step();
        check("t4_done",      32'(out_valid), 32'h0);
        step();
        check("t4_single",    32'(out_valid), 32'h0);

        // 5: re-arm of the bit being acknowledged
        do_reset();
        out_ready = 1'b0; req_in = 8'h60; step();
        req_in = 8'h00; step();
        check("t5_present", 32'(out_onehot), 32'h20);
        out_ready = 1'b1; req_in = 8'h20; step();
        check("t5_no_ovf",  32'(overflow), 32'h0);
        check("t5_pending", 32'(pending), 32'h60);
        check("t5_next",    32'(out_onehot), 32'h40);
        req_in = 8'h00; step();
        check("t5_again",   32'(out_onehot), 32'h20);
        step();
        check("t5_idle",    32'(out_valid), 32'h0);

        // 6: reset in the middle of a presentation
        do_reset();
        out_ready = 1'b0; req_in = 8'hFF; step();
        req_in = 8'h00; step();
        check("t6_pending_full", 32'(pending), 32'hFF);
        out_ready = 1'b1; step();
        check("t6_moved_on", 32'(out_onehot), 32'h02);
        out_ready = 1'b0; rst = 1'b1; step();
        check("t6_rst_valid",   32'(out_valid), 32'h0);
        check("t6_rst_onehot",  32'(out_onehot), 32'h0);
        check("t6_rst_pending", 32'(pending), 32'h0);
        check("t6_rst_ovf",     32'(overflow), 32'h0);
        rst = 1'b0; out_ready = 1'b1; req_in = 8'h81; step();
        req_in = 8'h00; step();
        check("t6_first_after", 32'(out_onehot), 32'h01);
        step();
        step();
        check("t6_drained", 32'(out_valid), 32'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
